cva6_hpdcache_axi_read_scheduler: RTL

Schedules read miss requests from N cache requesters (I$, D$, ...) onto the single AXI read-address stream of the cache subsystem. Allocates a free AXI transaction ID per request, limits per-requester outstanding reads, and routes R-channel beats back to the owning requester with the requester's original transaction ID restored. Sits between the cache miss interfaces and the memory-to-AXI read adapter.

---
 rtl/cva6_hpdcache_axi_sched_pkg.sv | 19 +
 rtl/cva6_hpdcache_rr_arbiter.sv | 44 ++++
 rtl/cva6_hpdcache_axi_read_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cva6_hpdcache_axi_sched_pkg.sv
// cva6_hpdcache_axi_sched_pkg: shared types for the AXI read scheduler.
// Entry fields are sized for the widest supported owner/TID; unused upper bits stay zero.
package cva6_hpdcache_axi_sched_pkg;

    localparam int unsigned MaxOwnerWidth = 8;
    localparam int unsigned MaxTidWidth   = 16;

    typedef enum logic {
        IDLE,
        HOLD
    } sched_state_e;

    typedef struct packed {
        logic                     valid;
        logic [MaxOwnerWidth-1:0] owner;
        logic [MaxTidWidth-1:0]   tid;
    } id_entry_t;

endpackage

// File: rtl/cva6_hpdcache_rr_arbiter.sv
// cva6_hpdcache_rr_arbiter: round-robin pick starting at an internal pointer.
// The pointer only moves when the caller commits a grant, and moves past the committed index.
module cva6_hpdcache_rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    input  logic [$clog2(N)-1:0] adv_idx_i,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int unsigned IdxW = $clog2(N);
    localparam int unsigned SumW = IdxW + 1;

    logic [IdxW-1:0] ptr_q;
    logic [N-1:0]    rot;
    logic [SumW-1:0] sum;

    // Rotate so bit 0 is the requester at the pointer; scan downward so the lowest offset wins.
    always_comb begin
        rot         = N'({req_i, req_i} >> ptr_q);
        gnt_valid_o = 1'b0;
        sum         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_valid_o = 1'b1;
                sum         = {1'b0, ptr_q} + SumW'(k);
            end
        end
        gnt_idx_o = (sum >= SumW'(N)) ? IdxW'(sum - SumW'(N)) : IdxW'(sum);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (adv_i) begin
            ptr_q <= (adv_idx_i == IdxW'(N - 1)) ? '0 : adv_idx_i + 1'b1;
        end
    end

endmodule

// File: rtl/cva6_hpdcache_axi_read_scheduler.sv
// cva6_hpdcache_axi_read_scheduler: maps requester read misses onto AXI IDs and routes R beats back.
// The address side holds its winner/ID stable once presented; the response side is a pure lookup.
module cva6_hpdcache_axi_read_scheduler
    import cva6_hpdcache_axi_sched_pkg::*;
#(
    parameter int unsigned NReq           = 2,
    parameter int unsigned NumIds         = 8,
    parameter int unsigned IdWidth        = 3,
    parameter int unsigned TidWidth       = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ReqWidth       = 64,
    parameter int unsigned RespWidth      = 64
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [NReq-1:0]                                req_valid_i,
    output logic [NReq-1:0]                                req_ready_o,
    input  logic [NReq-1:0][ReqWidth-1:0]                  req_i,
    input  logic [NReq-1:0][TidWidth-1:0]                  req_tid_i,
    output logic                                           out_valid_o,
    input  logic                                           out_ready_i,
    output logic [ReqWidth-1:0]                            out_o,
    output logic [IdWidth-1:0]                             out_id_o,
    input  logic                                           rsp_valid_i,
    output logic                                           rsp_ready_o,
    input  logic [RespWidth-1:0]                           rsp_i,
    input  logic [IdWidth-1:0]                             rsp_id_i,
    input  logic                                           rsp_last_i,
    output logic [NReq-1:0]                                rsp_valid_o,
    input  logic [NReq-1:0]                                rsp_ready_i,
    output logic [RespWidth-1:0]                           rsp_o,
    output logic [TidWidth-1:0]                            rsp_tid_o,
    output logic                                           err_o,
    output logic [NReq-1:0][$clog2(MaxOutstanding+1)-1:0] outstanding_o
);

    localparam int unsigned OwnerW = $clog2(NReq);
    localparam int unsigned CntW   = $clog2(MaxOutstanding + 1);

    sched_state_e              state_q, state_d;
    logic [OwnerW-1:0]         winner_q, arb_idx, sel;
    logic [IdWidth-1:0]        id_q, free_id, sel_id;
    id_entry_t                 tbl_q [NumIds];
    id_entry_t                 ent, new_ent;
    logic [NReq-1:0][CntW-1:0] cnt_q;
    logic [NReq-1:0]           eligible, owner_oh;
    logic                      arb_valid, free_found, out_hs, hit, free_fire, err_q;

    // Lowest free ID from registered state, so an ID freed this cycle is not reused until the next.
    always_comb begin
        free_found = 1'b0;
        free_id    = '0;
        for (int k = NumIds - 1; k >= 0; k--) begin
            if (!tbl_q[k].valid) begin
                free_found = 1'b1;
                free_id    = IdWidth'(k);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NReq; i++) begin
            eligible[i] = req_valid_i[i] && (cnt_q[i] < CntW'(MaxOutstanding));
        end
    end

    cva6_hpdcache_rr_arbiter #(
        .N(NReq)
    ) i_arb (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (eligible),
        .adv_i      (out_hs),
        .adv_idx_i  (sel),
        .gnt_valid_o(arb_valid),
        .gnt_idx_o  (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        sel         = (state_q == HOLD) ? winner_q : arb_idx;
        sel_id      = (state_q == HOLD) ? id_q : free_id;
        out_valid_o = !rst_i && ((state_q == HOLD) || (arb_valid && free_found));
        out_hs      = out_valid_o && out_ready_i;
        out_o       = req_i[sel];
        out_id_o    = sel_id;
        for (int i = 0; i < NReq; i++) begin
            req_ready_o[i] = out_hs && (sel == OwnerW'(i));
        end
        if (out_valid_o) begin
            state_d = out_ready_i ? IDLE : HOLD;
        end
        new_ent = '{valid: 1'b1, owner: MaxOwnerWidth'(sel), tid: MaxTidWidth'(req_tid_i[sel])};
    end

    // Beats for an unallocated ID are swallowed (ready=1) and flagged one cycle later.
    always_comb begin
        ent = tbl_q[rsp_id_i];
        hit = ent.valid;
        for (int i = 0; i < NReq; i++) begin
            owner_oh[i] = (ent.owner == MaxOwnerWidth'(i));
        end
        rsp_valid_o = (!rst_i && hit && rsp_valid_i) ? owner_oh : '0;
        rsp_ready_o = !rst_i && (!hit || |(owner_oh & rsp_ready_i));
        rsp_o       = rsp_i;
        rsp_tid_o   = TidWidth'(ent.tid);
        free_fire   = rsp_valid_i && rsp_ready_o && hit && rsp_last_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            winner_q <= '0;
            id_q     <= '0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            for (int k = 0; k < NumIds; k++) begin
                tbl_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            err_q   <= rsp_valid_i && !hit;
            if (state_q == IDLE && state_d == HOLD) begin
                winner_q <= sel;
                id_q     <= sel_id;
            end
            if (free_fire) begin
                tbl_q[rsp_id_i].valid <= 1'b0;
            end
            if (out_hs) begin
                tbl_q[sel_id] <= new_ent;
            end
            for (int i = 0; i < NReq; i++) begin
                cnt_q[i] <= cnt_q[i] + CntW'(req_ready_o[i]) - CntW'(free_fire && owner_oh[i]);
            end
        end
    end

    assign err_o         = err_q;
    assign outstanding_o = cnt_q;

endmodule
